// File: rtl/stim_fifo.sv
// Show-ahead valid/ready FIFO between the stimulus driver and the DUT input.
// Optional high-water-mark tracking is enabled by defining STIM_FIFO_HWM_EN.
module stim_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   hwm
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count_next;
  logic             push;
  logic             pop;

  // Handshake flags come only from the registered count, so a same-cycle
  // pop never opens room for a push and a push never bypasses to the output.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + PW'(1);
    else if (pop && !push)
      count_next = count - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

`ifdef STIM_FIFO_HWM_EN
  // count_next never exceeds DEPTH, so the mark saturates on its own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hwm <= '0;
    else if (count_next > hwm)
      hwm <= count_next;
  end
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_stim_fifo.sv
// Self-checking bench for stim_fifo: vector table, directed corner cases and
// randomized bursts against a queue-based reference model.
module tb_stim_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;
  logic [CW-1:0]    hwm;

  stim_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .hwm       (hwm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q[$];
  int               hwm_m = 0;
  int               pushes = 0;
  int               pops   = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic void check_state(string tag);
    int exp_hwm;
`ifdef STIM_FIFO_HWM_EN
    exp_hwm = hwm_m;
`else
    exp_hwm = 0;
`endif
    chk({tag, ".count"}, int'(count), q.size());
    chk({tag, ".in_ready"}, int'(in_ready), (q.size() < DEPTH) ? 1 : 0);
    chk({tag, ".out_valid"}, int'(out_valid), (q.size() > 0) ? 1 : 0);
    chk({tag, ".hwm"}, int'(hwm), exp_hwm);
    if (q.size() > 0)
      chk({tag, ".out_data"}, int'(out_data), int'(q[0]));
  endfunction

  // One clock: predict push/pop from the model, advance, then compare.
  task automatic tick(string tag);
    bit               push;
    bit               pop;
    logic [WIDTH-1:0] d;
    push = in_valid && (q.size() < DEPTH);
    pop  = out_ready && (q.size() > 0);
    d    = in_data;
    if (pop)
      chk({tag, ".pop_data"}, int'(out_data), int'(q[0]));
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (push) begin
      q.push_back(d);
      pushes++;
    end
    if (q.size() > hwm_m)
      hwm_m = q.size();
    check_state(tag);
  endtask

  task automatic drive(bit v, logic [WIDTH-1:0] d, bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Asynchronous assertion checked before any edge; release is edge-aligned.
  task automatic do_reset(string tag);
    drive(1'b0, '0, 1'b0);
    rst = 1'b0;
    #1;
    q.delete();
    hwm_m = 0;
    chk({tag, ".async_count"}, int'(count), 0);
    chk({tag, ".async_out_valid"}, int'(out_valid), 0);
    chk({tag, ".async_in_ready"}, int'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check_state({tag, ".released"});
  endtask

  typedef struct {
    bit               v;
    logic [WIDTH-1:0] d;
    bit               r;
    int               c;
    bit               ov;
    bit               ir;
    int               od;  // -1: out_data not checked
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 1'b1, 'h11};
    tbl[1] = '{1'b1, 8'h22, 1'b1, 1, 1'b1, 1'b1, 'h22};
    tbl[2] = '{1'b0, 8'h33, 1'b0, 1, 1'b1, 1'b1, 'h22};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 2, 1'b1, 1'b1, 'h22};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 'h44};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, -1};
    tbl[6] = '{1'b0, 8'h99, 1'b1, 0, 1'b0, 1'b1, -1};
    tbl[7] = '{1'b1, 8'h55, 1'b1, 1, 1'b1, 1'b1, 'h55};
    tbl[8] = '{1'b1, 8'h66, 1'b1, 1, 1'b1, 1'b1, 'h66};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, -1};

    // Reset then idle
    do_reset("reset");
    tick("idle");

    // Table vectors
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_count", i), int'(count), tbl[i].c);
      chk($sformatf("vec%0d.tbl_out_valid", i), int'(out_valid), int'(tbl[i].ov));
      chk($sformatf("vec%0d.tbl_in_ready", i), int'(in_ready), int'(tbl[i].ir));
      if (tbl[i].od >= 0)
        chk($sformatf("vec%0d.tbl_out_data", i), int'(out_data), tbl[i].od);
    end

    // Fill to full, then a rejected 17th push
    do_reset("fill_rst");
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0);
      tick("fill");
    end
    chk("full.count", int'(count), 16);
    chk("full.in_ready", int'(in_ready), 0);
    drive(1'b1, 8'hAA, 1'b0);
    tick("push17");
    chk("push17.count", int'(count), 16);

    // Full with push and pop together: only the pop happens
    drive(1'b1, 8'hBB, 1'b1);
    tick("full_pp");
    chk("full_pp.count", int'(count), 15);

    // Drain the remainder in order
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain.seq", int'(out_data), i);
      drive(1'b0, '0, 1'b1);
      tick("drain");
    end
    chk("drain.count", int'(count), 0);
    chk("drain.out_valid", int'(out_valid), 0);

    // Simultaneous push/pop at count=4
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, WIDTH'(8'hC0 + i), 1'b0);
      tick("pre4");
    end
    drive(1'b1, 8'h55, 1'b1);
    tick("pp4");
    chk("pp4.count", int'(count), 4);
    for (int i = 1; i < 4; i++) begin
      chk("pp4.order", int'(out_data), 'hC0 + i);
      drive(1'b0, '0, 1'b1);
      tick("pp4_drain");
    end
    chk("pp4.last", int'(out_data), 'h55);
    drive(1'b0, '0, 1'b1);
    tick("pp4_drain");

    // Reset mid-burst with 5 entries
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, WIDTH'(8'h70 + i), 1'b0);
      tick("mid");
    end
    chk("mid.count", int'(count), 5);
    do_reset("mid_rst");

    // High-water mark: push 9, pop 9, push 3
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0);
      tick("hwm_push");
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, '0, 1'b1);
      tick("hwm_pop");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'(8'hE0 + i), 1'b0);
      tick("hwm_push2");
    end
    chk("hwm.count", int'(count), 3);
`ifdef STIM_FIFO_HWM_EN
    chk("hwm.value", int'(hwm), 9);
`else
    chk("hwm.value", int'(hwm), 0);
`endif

    // Randomized bursts with per-burst valid/ready biases
    pushes = 0;
    pops   = 0;
    for (int b = 0; b < 40; b++) begin
      int len;
      int pv;
      int pr;
      len = int'($urandom_range(4, 30));
      pv  = int'($urandom_range(10, 100));
      pr  = int'($urandom_range(10, 100));
      for (int c = 0; c < len; c++) begin
        drive(($urandom_range(0, 99) < pv) ? 1'b1 : 1'b0,
              WIDTH'($urandom),
              ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0);
        tick($sformatf("rnd%0d", b));
      end
    end
    // Flush whatever is left so every pushed item is matched
    for (int c = 0; c < DEPTH + 2; c++) begin
      drive(1'b0, '0, 1'b1);
      tick("flush");
    end
    chk("rnd.balance", int'(count), pushes - pops + 3);

    drive(1'b0, '0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
